// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared op and state encodings for the multicycle shift unit
package shift_pkg;

  // Command encodings on the op bus; 110/111 fall through as NOP
  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SLL  = 3'b010;
  localparam logic [2:0] OP_SRL  = 3'b011;
  localparam logic [2:0] OP_SRA  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } stateT;

  // Only LOAD..ROR start a command; NOP and the two spare codes are ignored
  function automatic logic isValidOp(input logic [2:0] opCode);
    return (opCode >= OP_LOAD) && (opCode <= OP_ROR);
  endfunction

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational single-bit shift/rotate step
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] rNext
);

  // One-position move of the working value; unknown ops leave it untouched
  always_comb begin
    rNext = r;
    case (op)
      OP_SLL:  rNext = {r[WIDTH-2:0], 1'b0};
      OP_SRL:  rNext = {1'b0, r[WIDTH-1:1]};
      OP_SRA:  rNext = {r[WIDTH-1], r[WIDTH-1:1]};
      OP_ROR:  rNext = {r[0], r[WIDTH-1:1]};
      default: rNext = r;
    endcase
  end

endmodule

// File: rtl/shift_unit_seq.sv
// rtl/shift_unit_seq.sv - multicycle shifter, one bit per clock under start/done handshake
module shift_unit_seq
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] n_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  stateT            state;
  stateT            stateNext;
  logic [SHW-1:0]   count;
  logic [2:0]       opReg;
  logic [WIDTH-1:0] stepOut;
  logic [SHW-1:0]   nEff;
  logic             accept;
  logic             unusedNin;

  // Only the low SHW bits of the mux output form the shift count
  assign nEff      = n_in[SHW-1:0];
  assign unusedNin = ^n_in[WIDTH-1:SHW];

  // A command is taken only from IDLE and only for a real op
  assign accept = (state == ST_IDLE) && start && isValidOp(op);

  shift_step #(.WIDTH(WIDTH)) uStep (
    .op    (opReg),
    .r     (result),
    .rNext (stepOut)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= stateNext;
  end

  // Next-state: zero-count and LOAD skip straight to DONE; the step with count==1 is the last
  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if ((op == OP_LOAD) || (nEff == '0)) stateNext = ST_DONE;
          else                                 stateNext = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (count == SHW'(1)) stateNext = ST_DONE;
      end
      ST_DONE:  stateNext = ST_IDLE;
      default:  stateNext = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    busy = (state != ST_IDLE);
    done = (state == ST_DONE);
  end

  // Operand capture on accept, one step per SHIFT cycle, otherwise result holds for writeback
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result <= '0;
      count  <= '0;
      opReg  <= OP_NOP;
    end else if (accept) begin
      result <= data_in;
      count  <= nEff;
      opReg  <= op;
    end else if (state == ST_SHIFT) begin
      result <= stepOut;
      count  <= count - SHW'(1);
    end
  end

endmodule
